// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one physical-memory port between I-cache and D-cache
// One transaction at a time; grant, address, write data and command are registered at grant.
module cache_arbiter #(
  parameter bit D_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_last_d;
  logic           r_read;
  logic           r_write;
  logic [15:0]    r_addr;
  logic [127:0]   r_wdata;

  logic           w_i_req;
  logic           w_d_req;
  logic           w_grant_d;

  assign w_i_req   = i_pmem_read;
  assign w_d_req   = d_pmem_read | d_pmem_write;
  // D wins when alone, or on contention when I was granted last.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= ~D_FIRST;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 128'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state  <= SERVE_D;
            r_last_d <= 1'b1;
            r_addr   <= {d_pmem_address[15:4], 4'h0};
            r_wdata  <= d_pmem_wdata;
            r_write  <= d_pmem_write;
            r_read   <= ~d_pmem_write;
          end else if (w_i_req) begin
            r_state  <= SERVE_I;
            r_last_d <= 1'b0;
            r_addr   <= {i_pmem_address[15:4], 4'h0};
            r_write  <= 1'b0;
            r_read   <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = r_read;
  assign pmem_write   = r_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (r_state == SERVE_D) & pmem_resp;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. Accepts line-sized (128-bit, `lc3b_data`) read requests from the I-cache and read/write requests from the D-cache. Runs exactly one transaction at a time to memory, using a registered grant and round-robin fairness. Sits between both caches' `pmem_*` ports and the memory model or next cache level.

## Interface
Parameters:
- `D_FIRST`, default 1: requester favoured on the first contention after reset (1 = D-cache, 0 = I-cache).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_pmem_read`  in  1  I-cache line read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  16  I-cache byte address (`lc3b_word`).
- `i_pmem_rdata`  out  128  line returned to the I-cache.
- `i_pmem_resp`  out  1  I-cache transaction complete.
- `d_pmem_read`  in  1  D-cache line read request.
- `d_pmem_write`  in  1  D-cache line write-back request.
- `d_pmem_address`  in  16  D-cache byte address.
- `d_pmem_wdata`  in  128  D-cache write-back line.
- `d_pmem_rdata`  out  128  line returned to the D-cache.
- `d_pmem_resp`  out  1  D-cache transaction complete.
- `pmem_read`, `pmem_write`  out  1 each  memory command strobes.
- `pmem_address`  out  16  memory byte address; bits [3:0] always 0.
- `pmem_wdata`  out  128  memory write data.
- `pmem_rdata`  in  128  memory read data.
- `pmem_resp`  in  1  memory transaction complete.

## Operation
- The FSM has three states: IDLE, SERVE_I, SERVE_D. A one-bit `last_d` register records the requester granted most recently.
- IDLE, with only I requesting (`i_pmem_read`): go to SERVE_I.
- IDLE, with only D requesting (`d_pmem_read|d_pmem_write`): go to SERVE_D.
- IDLE, with both requesting: grant the requester not granted last, then set `last_d` accordingly.
- IDLE, with no request: stay in IDLE.
- Grant latch: on entry to a SERVE state, latch the address with bits [3:0] forced to 0. For SERVE_D, also latch the op (write if `d_pmem_write` is set, else read) and `d_pmem_wdata`.
  - `d_pmem_read` and `d_pmem_write` both high is treated as a write.
  - Requester input changes after the grant are ignored until the transaction completes.
- SERVE_x: drive the latched command and address to memory. Route `pmem_rdata` combinationally to both `i_pmem_rdata` and `d_pmem_rdata`.
- Resp routing: `pmem_resp` is forwarded combinationally only to the granted requester's `*_resp`; the other `*_resp` stays 0. On the `pmem_resp` cycle, the next state is IDLE.
- After its resp, a requester must drop its request by the next edge. A request still asserted in IDLE is treated as new.
- A D-cache write-back followed by a miss fill is two separate transactions; an I request may win in between.
- Reset, whether asserted in IDLE or in the middle of a transaction:
  - state becomes IDLE;
  - `last_d` becomes `~D_FIRST`, so the first contention grants the `D_FIRST` requester;
  - latched address, wdata and op become 0;
  - `pmem_read`, `pmem_write` and both `*_resp` become 0.
  - An in-flight memory operation is abandoned; the memory model must tolerate its strobe dropping.

## Timing
- Reset values: every output is 0. `*_rdata` follow `pmem_rdata`.
- Grant latency: a request sampled in IDLE at edge N produces `pmem_read` or `pmem_write` high in cycle N+1.
- Strobes stay high continuously from grant through the cycle where `pmem_resp` = 1, and are low in the following cycle (IDLE).
- There is at least one IDLE cycle between consecutive transactions, so the best-case period is memory latency + 1 cycle.
- Resp and rdata are forwarded in the same cycle (zero added latency). `pmem_resp` seen in IDLE is ignored.
- `pmem_address` and `pmem_wdata` come from registers and are stable for the whole transaction.

## Test plan
- Reset: assert `rst_n`=0 mid-SERVE_D write.
  - Required: `pmem_write`=0 immediately (asynchronous); all resp=0.
  - Required: after release with both requesting, D (`D_FIRST`=1) is granted.
- Lone I read:
  - Stimulus: `i_pmem_read`=1, address 0x1237; memory returns line 0xA5…A5 after 3 cycles.
  - Required: `pmem_address`=0x1230; `pmem_read`=1 for exactly 3 cycles.
  - Required: `i_pmem_resp`=1 with `i_pmem_rdata`=0xA5…A5 in that last cycle; `d_pmem_resp`=0.
- Simultaneous requests, repeated 4 times (each requester re-asserts after its resp):
  - Required: grant order D, I, D, I; no requester is starved.
- D write-back then read:
  - Stimulus: `d_pmem_write`=1, address 0x4008, wdata 0x0123…; then `d_pmem_read` at 0x8000.
  - Required: `pmem_write` with address 0x4000 and the same wdata; then an IDLE cycle; then `pmem_read` at 0x8000.
- Input change after grant:
  - Stimulus: change `d_pmem_address` to 0xFFFF and drop `d_pmem_write` one cycle after grant.
  - Required: `pmem_address` and `pmem_write` hold their latched values until resp.
- Spurious `pmem_resp` in IDLE:
  - Required: no `*_resp` pulse; the state stays IDLE.
